// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch front end for the single-issue MIPS core.
// Owns the fetch PC, reads the combinational instruction memory, buffers
// {pc, instr} pairs in a small prefetch FIFO and hands them to decode with
// a valid/ready handshake. Handles branch/jump redirects (flush) and a
// halt/drain request.
//
// Optional feature macro: IFETCH_TRACE_EN (simulation-only fetch/redirect trace).
//
// Parameters:
//   RESET_PC     fetch word address loaded on reset
//   DEPTH        prefetch FIFO entries (2 or 4)
// Ports:
//   Clock          sole clock, rising edge
//   Reset_n        asynchronous active-low reset
//   ReadAddress    word address to instruction memory (fetch PC register)
//   Instruction    memory read data, combinational from ReadAddress
//   InstrOut       instruction at FIFO head
//   InstrPC        word address of InstrOut
//   InstrValid     FIFO not empty
//   InstrReady     decode accepts the head entry
//   Redirect       one-cycle taken branch/jump pulse
//   RedirectTarget new fetch word address
//   Halt           level request to stop fetching and drain
//   Halted         high while in the HALTED state
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        Clock,
  input  logic        Reset_n,
  output logic [31:0] ReadAddress,
  input  logic [31:0] Instruction,
  output logic [31:0] InstrOut,
  output logic [31:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  input  logic        Halt,
  output logic        Halted
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = 32;

  typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALTED} state_t;

  state_t          state, state_n;
  logic [AW-1:0]   fetch_pc, fetch_pc_n;
  logic [CW-1:0]   count, count_n, count_mid;
  logic [AW-1:0]   q_pc      [DEPTH];
  logic [AW-1:0]   q_pc_n    [DEPTH];
  logic [AW-1:0]   q_instr   [DEPTH];
  logic [AW-1:0]   q_instr_n [DEPTH];
  logic            valid_q, valid_n;
  logic            halted_q, halted_n;
  logic            pop, pop_eff, push, redirect_now;

  assign ReadAddress = fetch_pc;
  assign InstrOut    = q_instr[0];
  assign InstrPC     = q_pc[0];
  assign InstrValid  = valid_q;
  assign Halted      = halted_q;

  // State register plus FIFO/PC datapath registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      count    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      count    <= count_n;
      valid_q  <= valid_n;
      halted_q <= halted_n;
      q_pc     <= q_pc_n;
      q_instr  <= q_instr_n;
    end
  end

  // Next-state, push/pop decisions and FIFO update. The head lives in
  // entry 0 so InstrOut/InstrPC come straight from flops.
  always_comb begin
    state_n      = state;
    fetch_pc_n   = fetch_pc;
    q_pc_n       = q_pc;
    q_instr_n    = q_instr;
    push         = 1'b0;
    pop          = valid_q & InstrReady;
    redirect_now = Redirect & (state != BOOT);
    pop_eff      = pop & ~redirect_now;
    count_mid    = count - CW'(pop_eff);

    case (state)
      BOOT:   state_n = RUN;
      RUN: begin
        if (Halt) state_n = DRAIN;
        else      push    = (count_mid < CW'(DEPTH));  // room, or a pop frees a slot
      end
      DRAIN: begin
        if (!Halt)                state_n = RUN;
        else if (count_mid == '0) state_n = HALTED;
      end
      HALTED: if (!Halt) state_n = RUN;
      default: state_n = BOOT;
    endcase

    if (redirect_now) begin
      state_n = RUN;
      push    = 1'b0;
    end

    // Shift out the head on pop; the vacated tail slot keeps stale data.
    if (pop_eff) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        q_pc_n[i]    = q_pc[i+1];
        q_instr_n[i] = q_instr[i+1];
      end
    end

    if (push) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CW'(i) == count_mid) begin
          q_pc_n[i]    = fetch_pc;
          q_instr_n[i] = Instruction;
        end
      end
      fetch_pc_n = fetch_pc + 32'd1;
    end

    if (redirect_now) begin
      fetch_pc_n = RedirectTarget;
      count_n    = '0;
    end else begin
      count_n    = count_mid + CW'(push);
    end

    valid_n  = (count_n != '0);
    halted_n = (state_n == HALTED);
  end

`ifdef IFETCH_TRACE_EN
  // Simulation-only trace of fetches and redirects.
  always @(posedge Clock) begin
    if (Reset_n) begin
      if (push)         $display("Fetch PC %d: %b", fetch_pc, Instruction);
      if (redirect_now) $display("Redirect -> %d", RedirectTarget);
    end
  end
`endif

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch front end for the single-issue MIPS core. It owns the fetch program counter and drives the word address into the combinational instruction memory. It captures the returned instruction word into a small prefetch FIFO and presents it to decode through a valid/ready handshake. It also handles branch/jump redirects, with flush, and a halt/drain request.

## Interface
- RESET_PC, default 0: fetch word address loaded on reset.
- DEPTH, default 2: prefetch FIFO entries; legal values are 2 and 4.

- Clock  in  1  sole clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- ReadAddress  out  32  word index to instruction memory; equals FetchPC.
- Instruction  in  32  memory read data, combinational from ReadAddress in the same cycle.
- InstrOut  out  32  instruction at the FIFO head.
- InstrPC  out  32  word address of InstrOut.
- InstrValid  out  1  FIFO not empty.
- InstrReady  in  1  decode accepts the head entry.
- Redirect  in  1  one-cycle pulse: branch/jump taken.
- RedirectTarget  in  32  new fetch word address.
- Halt  in  1  level request: stop fetching and drain.
- Halted  out  1  high in the HALTED state.

## Operation
- Internal state: FetchPC (32 bits), FIFO entries of {pc, instr}, a count, and a state register with states BOOT, RUN, DRAIN, HALTED.
- pop = InstrValid & InstrReady.
- push = state==RUN & !Redirect & (count<DEPTH | pop). A push writes {FetchPC, Instruction}; FetchPC <= FetchPC+1 mod 2^32, so 0xFFFFFFFF wraps to 0.
- A simultaneous push and pop is allowed when the FIFO is full; count is unchanged.
- Redirect takes priority over everything in every state except BOOT:
  - FIFO flushed (count <= 0) and the pop is ignored.
  - FetchPC <= RedirectTarget.
  - No push that cycle.
  - Next state is RUN.
- BOOT → RUN on the first edge after reset; no push occurs in BOOT.
- RUN → DRAIN when Halt=1 and Redirect=0; no push in that cycle.
- DRAIN: no pushes. Pops continue.
  - Halt=0 → RUN.
  - FIFO empty (count after update ==0) → HALTED.
- HALTED: ReadAddress is frozen. Halt=0 → RUN, resuming at FetchPC.
- Order is preserved: entries leave in push order, with no drops and no duplicates.
- InstrOut and InstrPC are stale when InstrValid=0; checkers sample them only when InstrValid=1.

## Timing
- Reset values:
  - ReadAddress = RESET_PC.
  - InstrValid = 0, Halted = 0.
  - InstrOut = 0, InstrPC = 0; all FIFO storage is cleared.
  - State = BOOT.
- Reset assertion acts immediately (asynchronous), including mid-transfer. Deassertion is sampled at the next edge.
- First valid instruction: InstrValid rises after the 2nd rising edge following reset release.
- Redirect sampled at edge N:
  - InstrValid = 0 after N.
  - Target instruction valid after N+1.
- Redirect-to-use latency is 2 cycles.
- Throughput is 1 instruction per cycle when InstrReady is held high.
- Halted rises on the edge that empties the FIFO in DRAIN. If the FIFO is already empty when Halt is seen, Halted rises 2 edges after Halt is sampled (RUN→DRAIN, then DRAIN→HALTED).
- InstrValid, InstrOut and InstrPC are registered and have no combinational path from InstrReady. ReadAddress is a register output.

## Configuration
- IFETCH_TRACE_EN:
  - Defined: on every push, a simulation-only $display prints "Fetch PC %d: %b" with the pc and instruction. On every redirect it prints "Redirect -> %d".
  - Undefined: no simulation output.
- Synthesized logic is identical in both cases.

## Test plan
- Reset, RESET_PC=0, mem[0]=0x20090004, mem[1]=0x200A000F, InstrReady=1 → after edge 2: InstrOut=0x20090004, InstrPC=0. After edge 3: InstrOut=0x200A000F, InstrPC=1.
- InstrReady=0 for 5 cycles, DEPTH=2 → FIFO holds PC0 and PC1, ReadAddress holds 2. Releasing InstrReady delivers PC0, 1, 2, 3 back-to-back with no gaps.
- FIFO full and Redirect with RedirectTarget=4 → InstrValid=0 the next cycle. The following cycle shows InstrPC=4 with InstrOut=mem[4], and the old entries never appear.
- Halt=1 with 2 entries and InstrReady=1 → both drain, then Halted=1 and ReadAddress is constant. Halt=0 → Halted=0 and fetching resumes at the frozen address.
- Redirect with RedirectTarget=0xFFFFFFFF → InstrPC sequence 0xFFFFFFFF, 0x00000000.
- Reset_n pulled low mid-cycle with 2 valid entries → InstrValid=0 and ReadAddress=RESET_PC immediately, without waiting for a clock edge.
